// File: rtl/password_entry_ctrl_if.sv
// Button/switch inputs and status outputs of the password entry controller.
// master = stimulus side (buttons, switches); slave = controller.
interface password_entry_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  logic [DIGIT_W-1:0]            sw_digit;
  logic                          enter_pushed;
  logic                          clear_pushed;
  logic                          prog_pushed;
  logic                          unlocked;
  logic                          error;
  logic                          locked;
  logic [3:0]                    digit_cnt;
  logic [3:0]                    fail_cnt;
  logic [NUM_DIGITS*DIGIT_W-1:0] entry_buf;

  modport master (
    output sw_digit, enter_pushed, clear_pushed, prog_pushed,
    input  unlocked, error, locked, digit_cnt, fail_cnt, entry_buf
  );

  modport slave (
    input  sw_digit, enter_pushed, clear_pushed, prog_pushed,
    output unlocked, error, locked, digit_cnt, fail_cnt, entry_buf
  );
endinterface

// File: rtl/password_entry_ctrl.sv
// Password entry FSM with attempt counting and timed lockout; verdict 2 cycles after the last digit,
// pulse inputs only (no backpressure). Define PW_PROGRAM_EN to allow reprogramming the password from UNLOCKED.
module password_entry_ctrl #(
  parameter int                              NUM_DIGITS   = 4,
  parameter int                              DIGIT_W      = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]   PASSWORD     = 16'h1234,
  parameter int                              MAX_ATTEMPTS = 3,
  parameter int                              FAIL_CYCLES  = 50_000_000,
  parameter int                              LOCK_CYCLES  = 500_000_000
) (
  input  logic clk,
  input  logic reset,
  password_entry_ctrl_if.slave bus
);

  localparam int BUF_W = NUM_DIGITS * DIGIT_W;
  localparam int TMR_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

`ifdef PW_PROGRAM_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ENTRY = 3'd1, S_CHECK = 3'd2, S_FAIL = 3'd3,
    S_LOCKED = 3'd4, S_UNLOCKED = 3'd5, S_PROGRAM = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ENTRY = 3'd1, S_CHECK = 3'd2, S_FAIL = 3'd3,
    S_LOCKED = 3'd4, S_UNLOCKED = 3'd5
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   entry_buf_q, entry_buf_d;
  logic [3:0]         digit_cnt_q, digit_cnt_d;
  logic [3:0]         fail_cnt_q, fail_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               unlocked_q, unlocked_d;
  logic               error_q, error_d;
  logic               locked_q, locked_d;
  logic [BUF_W-1:0]   pw_q;

  // Digit insertion: IDLE always writes position 0 into an empty buffer.
  logic [3:0]         ins_pos;
  logic [BUF_W-1:0]   ins_buf;
  logic               ins_last;

  always_comb begin
    ins_pos = (state_q == S_IDLE) ? 4'd0 : digit_cnt_q;
    ins_buf = (state_q == S_IDLE) ? '0 : entry_buf_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (ins_pos == 4'(i)) begin
        ins_buf[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = bus.sw_digit;
      end
    end
    ins_last = (ins_pos == 4'(NUM_DIGITS-1));
  end

`ifdef PW_PROGRAM_EN
  logic [BUF_W-1:0] pw_d;
`else
  logic unused_prog;
  assign unused_prog = bus.prog_pushed;
  assign pw_q        = PASSWORD;
`endif

  always_comb begin
    state_d     = state_q;
    entry_buf_d = entry_buf_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    timer_d     = '0;
`ifdef PW_PROGRAM_EN
    pw_d        = pw_q;
`endif
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (bus.clear_pushed) begin
          state_d     = S_IDLE;
          entry_buf_d = '0;
          digit_cnt_d = '0;
        end else if (bus.enter_pushed) begin
          entry_buf_d = ins_buf;
          digit_cnt_d = ins_pos + 4'd1;
          state_d     = ins_last ? S_CHECK : S_ENTRY;
        end
      end
      S_CHECK: begin
        if (entry_buf_q == pw_q) begin
          state_d    = S_UNLOCKED;
          fail_cnt_d = '0;
        end else if (fail_cnt_q >= 4'(MAX_ATTEMPTS-1)) begin
          state_d    = S_LOCKED;
          fail_cnt_d = 4'(MAX_ATTEMPTS);
        end else begin
          state_d    = S_FAIL;
          fail_cnt_d = fail_cnt_q + 4'd1;
        end
      end
      S_FAIL: begin
        if (timer_q == TMR_W'(FAIL_CYCLES-1)) begin
          state_d     = S_IDLE;
          entry_buf_d = '0;
          digit_cnt_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_LOCKED: begin
        if (timer_q == TMR_W'(LOCK_CYCLES-1)) begin
          state_d     = S_IDLE;
          entry_buf_d = '0;
          digit_cnt_d = '0;
          fail_cnt_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_UNLOCKED: begin
        if (bus.clear_pushed) begin
          state_d     = S_IDLE;
          entry_buf_d = '0;
          digit_cnt_d = '0;
`ifdef PW_PROGRAM_EN
        end else if (bus.prog_pushed) begin
          state_d     = S_PROGRAM;
          entry_buf_d = '0;
          digit_cnt_d = '0;
`endif
        end
      end
`ifdef PW_PROGRAM_EN
      S_PROGRAM: begin
        if (bus.clear_pushed) begin
          state_d     = S_UNLOCKED;
          entry_buf_d = '0;
          digit_cnt_d = '0;
        end else if (bus.enter_pushed) begin
          entry_buf_d = ins_buf;
          digit_cnt_d = ins_pos + 4'd1;
          if (ins_last) begin
            pw_d    = ins_buf;
            state_d = S_UNLOCKED;
          end
        end
      end
`endif
      default: begin
        state_d     = S_IDLE;
        entry_buf_d = '0;
        digit_cnt_d = '0;
      end
    endcase
    unlocked_d = (state_d == S_UNLOCKED);
    error_d    = (state_d == S_FAIL);
    locked_d   = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      entry_buf_q <= '0;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
      unlocked_q  <= 1'b0;
      error_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_buf_q <= entry_buf_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
      unlocked_q  <= unlocked_d;
      error_q     <= error_d;
      locked_q    <= locked_d;
    end
  end

`ifdef PW_PROGRAM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pw_q <= PASSWORD;
    else        pw_q <= pw_d;
  end
`endif

  assign bus.unlocked  = unlocked_q;
  assign bus.error     = error_q;
  assign bus.locked    = locked_q;
  assign bus.digit_cnt = digit_cnt_q;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.entry_buf = entry_buf_q;

endmodule

// File: doc/password_entry_ctrl.md
Name: password_entry_ctrl

Overview:
- Sequences password entry on the Basys 3 design.
- Consumes single-cycle button-pushed pulses from the per-button debounce/edge FSMs, latches digits from the switches, and compares the completed code against a stored password.
- Counts failed attempts and enforces a timed lockout.
- Drives the unlock/error/lock status outputs consumed by the LED and 7-segment display logic.

Parameters:
- NUM_DIGITS, 4: digits per password (1..8).
- DIGIT_W, 4: bits per digit.
- PASSWORD, 16'h1234: default password, NUM_DIGITS*DIGIT_W bits, digit 0 in the MS nibble.
- MAX_ATTEMPTS, 3: consecutive failures that trigger lockout (>=1).
- FAIL_CYCLES, 50_000_000: clk cycles the error indication is held.
- LOCK_CYCLES, 500_000_000: clk cycles the lockout lasts.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- sw_digit  input  DIGIT_W  digit value from the switches.
- enter_pushed  input  1  single-cycle pulse; latch sw_digit.
- clear_pushed  input  1  single-cycle pulse; abort entry or relock.
- prog_pushed  input  1  single-cycle pulse; start password reprogramming (PW_PROGRAM_EN only).
- unlocked  output  1  high while in UNLOCKED.
- error  output  1  high while in FAIL.
- locked  output  1  high while in LOCKED.
- digit_cnt  output  4  digits entered so far in the current entry.
- fail_cnt  output  4  consecutive failed attempts.
- entry_buf  output  NUM_DIGITS*DIGIT_W  digits entered so far, for display; unentered positions are 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - unlocked, error and locked = 0.
  - digit_cnt, fail_cnt and entry_buf = 0.
  - Timer = 0; password register = PASSWORD.
- Status outputs are registered and decoded from state only.
- IDLE:
  - enter_pushed: store sw_digit at position 0, digit_cnt = 1, go to ENTRY.
  - If NUM_DIGITS = 1, go directly to CHECK.
- ENTRY:
  - enter_pushed: store sw_digit at position digit_cnt, increment digit_cnt.
  - When the stored digit is the last one, digit_cnt = NUM_DIGITS and the next state is CHECK.
- CHECK (exactly one cycle):
  - Compare entry_buf with the password register.
  - Match: go to UNLOCKED, fail_cnt = 0.
  - Mismatch: fail_cnt + 1. If the new value equals MAX_ATTEMPTS, go to LOCKED; otherwise go to FAIL.
  - Any input pulse arriving during CHECK is ignored.
- FAIL:
  - Timer counts FAIL_CYCLES, then go to IDLE with entry_buf = 0 and digit_cnt = 0.
  - All pulses are ignored.
- LOCKED:
  - Timer counts LOCK_CYCLES, then go to IDLE with fail_cnt = 0 and entry_buf = 0.
  - All pulses are ignored, including clear.
- UNLOCKED:
  - Held indefinitely.
  - clear_pushed: go to IDLE with entry_buf = 0 and digit_cnt = 0.
- clear_pushed in IDLE or ENTRY: entry_buf = 0, digit_cnt = 0, go to IDLE; no attempt is counted.
- Simultaneous enter_pushed and clear_pushed: clear wins and the digit is discarded.
- Timer: width is clog2(LOCK_CYCLES). It is cleared on every state entry and runs only in FAIL and LOCKED.
- Latency:
  - Last enter pulse to verdict = 2 cycles (ENTRY to CHECK to UNLOCKED/FAIL/LOCKED).
  - fail_cnt saturates at MAX_ATTEMPTS.
- Illegal state encodings recover to IDLE on the next cycle.

Optional Feature:
- Macro: PW_PROGRAM_EN.
- Defined:
  - prog_pushed in UNLOCKED enters state PROGRAM; entry_buf and digit_cnt are cleared.
  - Each enter_pushed shifts sw_digit into position digit_cnt.
  - After NUM_DIGITS digits, entry_buf is copied into the password register on the same cycle the state returns to UNLOCKED.
  - clear_pushed in PROGRAM aborts: password unchanged, state returns to UNLOCKED.
  - The password register is reset to PASSWORD only by reset.
- Not defined: prog_pushed is ignored, no PROGRAM state exists, and the password is the constant PASSWORD.

Test Plan:
- All tests use FAIL_CYCLES=5 and LOCK_CYCLES=20.
- Correct code: enter 1,2,3,4 → 2 cycles after the 4th pulse unlocked=1, fail_cnt=0; clear_pushed → IDLE, unlocked=0, entry_buf=0.
- Wrong code: enter 1,2,3,5 → error=1 for exactly 5 cycles, fail_cnt=1, then IDLE with digit_cnt=0.
- Lockout: three wrong codes → locked=1 after the 3rd; enter and clear pulses ignored; after 20 cycles locked=0, fail_cnt=0; a correct code then unlocks.
- Abort:
  - Enter 1,2 then clear → digit_cnt=0, fail_cnt unchanged.
  - Enter and clear on the same cycle → digit discarded.
  - Async reset mid-ENTRY → all outputs 0 immediately.
- Reprogram with PW_PROGRAM_EN defined: unlock, prog_pushed, enter 9,8,7,6 → unlocked=1; clear; 1,2,3,4 fails; 9,8,7,6 unlocks.
- Reprogram with PW_PROGRAM_EN undefined: prog_pushed in UNLOCKED has no effect and 1,2,3,4 still unlocks.
